up2_mem_arb: RTL and testbench
==============================

// Module: up2_mem_arb
// PURPOSE
//  Arbiter/sequencer for the up2 single-port program memory. Shares it between the UART
//  loader (write requester) and the fetch unit (read requester); one access at a time.
//  Sits between the loader/fetch logic and the memory instance inside the up2 top.
// PARAMETERS
//  ADDR_W   8  memory address width
//  DATA_W   8  memory data width
//  MEM_LAT  1  memory read latency: mem_rdata valid MEM_LAT cycles after the mem_en cycle (1..7)
// PORTS
//  clk        in   1       system clock, rising edge
//  nRst       in   1       asynchronous active-low reset
//  wr_req     in   1       loader write request; held until wr_gnt
//  wr_addr    in   ADDR_W  loader write address, stable while wr_req
//  wr_data    in   DATA_W  loader write data, stable while wr_req
//  wr_gnt     out  1       one-cycle pulse: write performed this cycle
//  rd_req     in   1       fetch read request; held until rd_gnt
//  rd_addr    in   ADDR_W  fetch read address, stable while rd_req
//  rd_gnt     out  1       one-cycle pulse: read issued this cycle
//  rd_valid   out  1       one-cycle pulse: rd_data holds read result
//  rd_data    out  DATA_W  registered read data, held until next rd_valid
//  fe_hold    in   1       1 = block new read grants (pipeline halt); loader unaffected
//  mem_en     out  1       memory enable
//  mem_we     out  1       memory write enable (only with mem_en)
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data
//  busy       out  1       1 whenever state != IDLE
// BEHAVIOUR
//  - One clock domain; nRst async active-low. Reset: all outputs 0, state IDLE, last_wr=0,
//    lat counter 0. Reset mid-read drops the access: no rd_valid after release.
//  - All outputs registered. States: IDLE, ACCESS, RD_WAIT.
//  - IDLE: eligible = wr_req, rd_req & ~fe_hold. None -> stay. Else pick winner, load
//    mem_addr/mem_wdata/mem_we, set mem_en=1 and matching gnt=1, go ACCESS.
//  - ACCESS (exactly 1 cycle): mem_en/gnt high. Write -> IDLE (mem_en,gnt cleared).
//    Read -> RD_WAIT, lat counter = MEM_LAT.
//  - RD_WAIT: decrement counter; on the cycle mem_rdata is valid (MEM_LAT cycles after
//    ACCESS), capture rd_data, rd_valid=1 next cycle, return to IDLE same edge.
//  - Latency: req high at edge k -> gnt high cycle k+1; read rd_valid at cycle k+2+MEM_LAT.
//  - Requester must drop req the cycle after gnt; a req still high in IDLE is a new request.
//  - fe_hold rising during RD_WAIT does not cancel an issued read.
//  - Simultaneous wr_req & eligible rd_req: see CONFIGURATION. Back-to-back accesses
//    need IDLE between them (write min 2 cycles, read min 2+MEM_LAT cycles).
//  - mem_we never high without mem_en; mem_addr/mem_wdata hold last value when idle.
// CONFIGURATION
//  ARB_RR_EN undefined: fixed priority, write always wins (load completes before fetch).
//  ARB_RR_EN defined: round robin on conflict; last_wr flag records last winner, loser of
//    previous conflict wins next; last_wr updated on every grant. No-conflict grants as usual.
// STRUCTURE
//  Shared package up2_pkg: state encoding constants (ST_IDLE=2'd0, ST_ACCESS=2'd1,
//  ST_RD_WAIT=2'd2), default widths, MEM_LAT max. Single module; no sub-module needed
//  (winner select is a few gates, inline).
// TESTING
//  1 Reset: nRst=0 mid-RD_WAIT -> all outputs 0; after release no rd_valid; busy=0.
//  2 Write only: wr_req, addr 8'h10, data 8'hA5 -> next cycle mem_en=1, mem_we=1,
//    mem_addr=10, mem_wdata=A5, wr_gnt=1 for one cycle; then IDLE.
//  3 Read, MEM_LAT=1: rd_req addr 8'h10 (mem holds A5) -> rd_gnt cycle k+1, rd_valid
//    and rd_data=A5 at cycle k+3; repeat MEM_LAT=3 -> rd_valid at k+5.
//  4 Conflict, fixed priority: wr_req & rd_req held -> write granted every time until
//    wr_req drops, then read. With ARB_RR_EN: grants alternate W,R,W,R.
//  5 fe_hold=1 with rd_req=1 -> no rd_gnt, busy=0 for 10 cycles; wr_req still granted;
//    fe_hold=0 -> rd_gnt next cycle.
//  6 Loader burst of 4 writes then 4 reads (addr 0..3) -> rd_data matches written data.

Source files
------------

// File: rtl/up2_pkg.sv
// Shared definitions for the up2 memory arbiter: state encoding, default
// widths and the largest supported memory read latency.
package up2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RD_WAIT = 2'd2
    } state_t;

    localparam int unsigned ADDR_W_DEF  = 8;
    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned MEM_LAT_MAX = 7;
    localparam int unsigned CNT_W       = $clog2(MEM_LAT_MAX + 1);

endpackage

// File: rtl/up2_mem_arb.sv
// up2_mem_arb: shares the single-port program memory between the UART loader
// (writes) and the fetch unit (reads), one access at a time.
// Optional feature macro ARB_RR_EN: round-robin arbitration on a
// simultaneous write/read request; undefined gives fixed write priority.
module up2_mem_arb
    import up2_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              fe_hold,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               wr_elig, rd_elig, any_req, pick_wr;
    logic               wr_gnt_nxt, rd_gnt_nxt, rd_valid_nxt;
    logic               mem_en_nxt, mem_we_nxt, busy_nxt;
    logic [ADDR_W-1:0]  mem_addr_nxt;
    logic [DATA_W-1:0]  mem_wdata_nxt, rd_data_nxt;

    assign wr_elig = wr_req;
    assign rd_elig = rd_req & ~fe_hold;
    assign any_req = wr_elig | rd_elig;

`ifdef ARB_RR_EN
    logic last_wr;

    // On conflict the loser of the previous grant wins
    always_comb pick_wr = (wr_elig && rd_elig) ? ~last_wr : wr_elig;

    // Remember which requester won the most recent grant
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)
            last_wr <= 1'b0;
        else if (state == ST_IDLE && any_req)
            last_wr <= pick_wr;
    end
`else
    // Fixed priority: a pending write always beats a read
    always_comb pick_wr = wr_elig;
`endif

    // State, latency counter and all registered outputs
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            wr_gnt    <= 1'b0;
            rd_gnt    <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            wr_gnt    <= wr_gnt_nxt;
            rd_gnt    <= rd_gnt_nxt;
            rd_valid  <= rd_valid_nxt;
            rd_data   <= rd_data_nxt;
            mem_en    <= mem_en_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            busy      <= busy_nxt;
        end
    end

    // Next-state selection
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (any_req) state_nxt = ST_ACCESS;
            ST_ACCESS:  state_nxt = mem_we ? ST_IDLE : ST_RD_WAIT;
            ST_RD_WAIT: if (cnt == CNT_W'(1)) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs and the latency counter
    always_comb begin
        wr_gnt_nxt    = 1'b0;
        rd_gnt_nxt    = 1'b0;
        rd_valid_nxt  = 1'b0;
        mem_en_nxt    = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        rd_data_nxt   = rd_data;
        cnt_nxt       = cnt;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    mem_en_nxt   = 1'b1;
                    mem_we_nxt   = pick_wr;
                    mem_addr_nxt = pick_wr ? wr_addr : rd_addr;
                    if (pick_wr) mem_wdata_nxt = wr_data;
                    wr_gnt_nxt   = pick_wr;
                    rd_gnt_nxt   = ~pick_wr;
                end
            end
            ST_ACCESS: begin
                if (!mem_we) cnt_nxt = CNT_W'(MEM_LAT);
            end
            ST_RD_WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    rd_data_nxt  = mem_rdata;
                    rd_valid_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: ;
        endcase
        busy_nxt = (state_nxt != ST_IDLE);
    end

endmodule

// File: tb/tb_up2_mem_arb.sv
// Directed bench for up2_mem_arb: one instance with MEM_LAT=1 (a_*) and one
// with MEM_LAT=3 (b_*) share the requester inputs; each has its own memory
// model that drives valid data only in the exact latency cycle.
module tb_up2_mem_arb;

    logic       clk = 1'b0;
    logic       nrst;
    logic       wr_req, rd_req, fe_hold;
    logic [7:0] wr_addr, wr_data, rd_addr;

    logic       a_wr_gnt, a_rd_gnt, a_rd_valid, a_mem_en, a_mem_we, a_busy;
    logic [7:0] a_rd_data, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic       b_wr_gnt, b_rd_gnt, b_rd_valid, b_mem_en, b_mem_we, b_busy;
    logic [7:0] b_rd_data, b_mem_addr, b_mem_wdata, b_mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    up2_mem_arb #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1)) dut_a (
        .clk(clk), .nRst(nrst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(a_wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(a_rd_gnt),
        .rd_valid(a_rd_valid), .rd_data(a_rd_data), .fe_hold(fe_hold),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    up2_mem_arb #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(3)) dut_b (
        .clk(clk), .nRst(nrst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(b_wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(b_rd_gnt),
        .rd_valid(b_rd_valid), .rd_data(b_rd_data), .fe_hold(fe_hold),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    // Memory models: 0xEE outside the single cycle the read data is valid
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [2:0] va, vb;
    logic [7:0] da [3];
    logic [7:0] db [3];

    always @(posedge clk) begin
        if (a_mem_en && a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
        va    <= {va[1:0], a_mem_en & ~a_mem_we};
        da[0] <= mem_a[a_mem_addr];
        da[1] <= da[0];
        da[2] <= da[1];
        if (b_mem_en && b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
        vb    <= {vb[1:0], b_mem_en & ~b_mem_we};
        db[0] <= mem_b[b_mem_addr];
        db[1] <= db[0];
        db[2] <= db[1];
    end

    assign a_mem_rdata = va[0] ? da[0] : 8'hEE;
    assign b_mem_rdata = vb[2] ? db[2] : 8'hEE;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((a_busy || b_busy) && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (a_busy || b_busy) begin
            errors++;
            $display("FAIL wait_idle: busy a=%b b=%b, required 0 0", a_busy, b_busy);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        wr_req = 0; rd_req = 0; fe_hold = 0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        #12;
        checks++;
        if ({a_wr_gnt, a_rd_gnt, a_rd_valid, a_rd_data, a_mem_en, a_mem_we,
             a_mem_addr, a_mem_wdata, a_busy} !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0", {a_wr_gnt, a_rd_gnt,
                     a_rd_valid, a_rd_data, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata, a_busy});
        end
        @(negedge clk);
        nrst = 1'b1;
        tick();
        tick();
        checks++;
        if (a_busy !== 1'b0 || a_mem_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b mem_en=%b, required 0 0", a_busy, a_mem_en);
        end
    endtask

    task automatic test_write();
        wr_req = 1; wr_addr = 8'h10; wr_data = 8'hA5;
        tick();
        checks++;
        if ({a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata, a_wr_gnt, a_rd_gnt, a_busy} !==
            {1'b1, 1'b1, 8'h10, 8'hA5, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL write_grant: en=%b we=%b addr=%h wdata=%h wgnt=%b rgnt=%b busy=%b, required 1 1 10 a5 1 0 1",
                     a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata, a_wr_gnt, a_rd_gnt, a_busy);
        end
        wr_req = 0;
        tick();
        checks++;
        if ({a_mem_en, a_mem_we, a_wr_gnt, a_busy, a_mem_addr, a_mem_wdata} !==
            {1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 8'hA5}) begin
            errors++;
            $display("FAIL write_done: en=%b we=%b wgnt=%b busy=%b addr=%h wdata=%h, required 0 0 0 0 10 a5",
                     a_mem_en, a_mem_we, a_wr_gnt, a_busy, a_mem_addr, a_mem_wdata);
        end
        wait_idle();
    endtask

    task automatic test_read_latency();
        rd_req = 1; rd_addr = 8'h10;
        tick();
        checks++;
        if ({a_rd_gnt, b_rd_gnt, a_mem_en, a_mem_we, a_mem_addr} !== {1'b1, 1'b1, 1'b1, 1'b0, 8'h10}) begin
            errors++;
            $display("FAIL read_grant: a_gnt=%b b_gnt=%b en=%b we=%b addr=%h, required 1 1 1 0 10",
                     a_rd_gnt, b_rd_gnt, a_mem_en, a_mem_we, a_mem_addr);
        end
        rd_req = 0;
        tick();
        checks++;
        if ({a_rd_gnt, a_rd_valid, b_rd_valid, a_mem_en} !== 4'b0000) begin
            errors++;
            $display("FAIL read_k2: gnt=%b a_valid=%b b_valid=%b en=%b, required 0 0 0 0",
                     a_rd_gnt, a_rd_valid, b_rd_valid, a_mem_en);
        end
        tick();
        checks++;
        if ({a_rd_valid, a_rd_data, b_rd_valid} !== {1'b1, 8'hA5, 1'b0}) begin
            errors++;
            $display("FAIL read_lat1: a_valid=%b a_data=%h b_valid=%b, required 1 a5 0",
                     a_rd_valid, a_rd_data, b_rd_valid);
        end
        tick();
        checks++;
        if ({a_rd_valid, a_busy, a_rd_data, b_rd_valid} !== {1'b0, 1'b0, 8'hA5, 1'b0}) begin
            errors++;
            $display("FAIL read_lat1_after: a_valid=%b a_busy=%b a_data=%h b_valid=%b, required 0 0 a5 0",
                     a_rd_valid, a_busy, a_rd_data, b_rd_valid);
        end
        tick();
        checks++;
        if ({b_rd_valid, b_rd_data} !== {1'b1, 8'hA5}) begin
            errors++;
            $display("FAIL read_lat3: b_valid=%b b_data=%h, required 1 a5", b_rd_valid, b_rd_data);
        end
        tick();
        checks++;
        if ({b_rd_valid, b_busy} !== 2'b00) begin
            errors++;
            $display("FAIL read_lat3_after: b_valid=%b b_busy=%b, required 0 0", b_rd_valid, b_busy);
        end
    endtask

    task automatic test_conflict();
        logic [3:0] got = '0;
        logic [3:0] exp_w;
        int         ng = 0;
        int         n  = 0;
`ifdef ARB_RR_EN
        exp_w = 4'b0101;
`else
        exp_w = 4'b1111;
`endif
        wait_idle();
        wr_req = 1; wr_addr = 8'h30; wr_data = 8'h11;
        rd_req = 1; rd_addr = 8'h10;
        while (ng < 4 && n < 60) begin
            tick();
            n++;
            if (a_wr_gnt || a_rd_gnt) begin
                got[ng] = a_wr_gnt;
                ng++;
            end
        end
        wr_req = 0;
        checks++;
        if (ng != 4 || got !== exp_w) begin
            errors++;
            $display("FAIL conflict_order: grants=%0d wr_pattern=%b, required 4 %b", ng, got, exp_w);
        end
`ifndef ARB_RR_EN
        n = 0;
        do begin
            tick();
            n++;
        end while (!a_wr_gnt && !a_rd_gnt && n < 20);
        checks++;
        if ({a_rd_gnt, a_wr_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL conflict_then_read: rgnt=%b wgnt=%b, required 1 0", a_rd_gnt, a_wr_gnt);
        end
`endif
        rd_req = 0;
        wait_idle();
    endtask

    task automatic test_fe_hold();
        int n = 0;
        fe_hold = 1; rd_req = 1; rd_addr = 8'h20;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({a_rd_gnt, a_busy, b_busy} !== 3'b000) begin
                errors++;
                $display("FAIL fe_hold_block: cycle %0d rgnt=%b busy=%b/%b, required 0 0 0",
                         i, a_rd_gnt, a_busy, b_busy);
            end
        end
        wr_req = 1; wr_addr = 8'h20; wr_data = 8'h5A;
        tick();
        checks++;
        if ({a_wr_gnt, a_rd_gnt, a_mem_addr} !== {1'b1, 1'b0, 8'h20}) begin
            errors++;
            $display("FAIL fe_hold_write: wgnt=%b rgnt=%b addr=%h, required 1 0 20",
                     a_wr_gnt, a_rd_gnt, a_mem_addr);
        end
        wr_req = 0;
        tick();
        fe_hold = 0;
        tick();
        checks++;
        if ({a_rd_gnt, a_mem_addr} !== {1'b1, 8'h20}) begin
            errors++;
            $display("FAIL fe_hold_release: rgnt=%b addr=%h, required 1 20", a_rd_gnt, a_mem_addr);
        end
        rd_req = 0;
        do begin
            tick();
            n++;
        end while (!a_rd_valid && n < 20);
        checks++;
        if ({a_rd_valid, a_rd_data} !== {1'b1, 8'h5A}) begin
            errors++;
            $display("FAIL fe_hold_data: valid=%b data=%h, required 1 5a", a_rd_valid, a_rd_data);
        end
        wait_idle();
    endtask

    task automatic test_burst();
        logic [7:0] pat [4];
        pat[0] = 8'h3C; pat[1] = 8'hC3; pat[2] = 8'h81; pat[3] = 8'h7E;
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            wait_idle();
            wr_req = 1; wr_addr = 8'(i); wr_data = pat[i];
            do begin
                tick();
                n++;
            end while (!a_wr_gnt && n < 20);
            wr_req = 0;
            checks++;
            if ({a_wr_gnt, b_wr_gnt} !== 2'b11) begin
                errors++;
                $display("FAIL burst_write%0d: wgnt a=%b b=%b, required 1 1", i, a_wr_gnt, b_wr_gnt);
            end
        end
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            wait_idle();
            rd_req = 1; rd_addr = 8'(i);
            do begin
                tick();
                n++;
            end while (!a_rd_gnt && n < 20);
            rd_req = 0;
            n = 0;
            while (!a_rd_valid && n < 20) begin
                tick();
                n++;
            end
            checks++;
            if ({a_rd_valid, a_rd_data} !== {1'b1, pat[i]}) begin
                errors++;
                $display("FAIL burst_read_a%0d: valid=%b data=%h, required 1 %h", i, a_rd_valid, a_rd_data, pat[i]);
            end
            n = 0;
            while (!b_rd_valid && n < 20) begin
                tick();
                n++;
            end
            checks++;
            if ({b_rd_valid, b_rd_data} !== {1'b1, pat[i]}) begin
                errors++;
                $display("FAIL burst_read_b%0d: valid=%b data=%h, required 1 %h", i, b_rd_valid, b_rd_data, pat[i]);
            end
        end
        wait_idle();
    endtask

    task automatic test_reset_mid_read();
        rd_req = 1; rd_addr = 8'h01;
        tick();
        rd_req = 0;
        tick();
        tick();
        checks++;
        if (b_busy !== 1'b1) begin
            errors++;
            $display("FAIL midread_setup: b_busy=%b, required 1", b_busy);
        end
        nrst = 1'b0;
        #1;
        checks++;
        if ({b_wr_gnt, b_rd_gnt, b_rd_valid, b_rd_data, b_mem_en, b_mem_we,
             b_mem_addr, b_mem_wdata, b_busy} !== 29'd0) begin
            errors++;
            $display("FAIL midread_reset_outputs: got %h, required 0", {b_wr_gnt, b_rd_gnt,
                     b_rd_valid, b_rd_data, b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata, b_busy});
        end
        tick();
        @(negedge clk);
        nrst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({b_rd_valid, b_busy, a_rd_valid, a_busy} !== 4'b0000) begin
                errors++;
                $display("FAIL midread_no_valid: cycle %0d b_valid=%b b_busy=%b a_valid=%b a_busy=%b, required 0 0 0 0",
                         i, b_rd_valid, b_busy, a_rd_valid, a_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_latency();
        test_conflict();
        test_fe_hold();
        test_burst();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
